// File: rtl/hazard_control_unit.sv
// hazard_control_unit: pipeline hazard controller for the 5-stage MIPS core.
// Handles load-use interlock with configurable latency, a MUL/DIV HI/LO busy
// interlock, taken-branch flush (overrides stalls) and $zero/unused-operand
// filtering.
// Optional build macro: HAZARD_PERF_CNT_EN adds stall/flush event counters.
module hazard_control_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int MULDIV_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead_ID_EX,
  input  logic [REG_ADDR_W-1:0] write_reg_ID_EX,
  input  logic [REG_ADDR_W-1:0] rs_IF_ID,
  input  logic [REG_ADDR_W-1:0] rt_IF_ID,
  input  logic                  rs_used_IF_ID,
  input  logic                  rt_used_IF_ID,
  input  logic                  md_start_ID_EX,
  input  logic                  hilo_read_IF_ID,
  input  logic                  branch_taken_EX,
  output logic                  ControlUnitRst,
  output logic                  pc_WE,
  output logic                  WE_if_id,
  output logic                  flush_if_id,
  output logic                  stall_active
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           ld_stall_cnt,
  output logic [31:0]           md_stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  localparam int LD_W = $clog2(LOAD_LAT + 1);
  localparam int MD_W = $clog2(MULDIV_LAT + 1);
  localparam logic [LD_W-1:0] LD_INIT = LD_W'(LOAD_LAT - 1);
  localparam logic [LD_W-1:0] LD_ONE  = LD_W'(1);
  localparam logic [MD_W-1:0] MD_INIT = MD_W'(MULDIV_LAT);
  localparam logic [MD_W-1:0] MD_ONE  = MD_W'(1);

  typedef enum logic {
    IDLE,
    LD_STALL
  } state_t;

  state_t            state, state_nx;
  logic [LD_W-1:0]   ld_cnt, ld_cnt_nx;
  logic [MD_W-1:0]   md_cnt, md_cnt_nx;

  logic lu;
  logic ld_stall;
  logic md_hazard;
  logic stall;
  logic flush;

  // Hazard detection terms; register $zero and unused operands never hazard.
  always_comb begin
    lu = MemRead_ID_EX && (write_reg_ID_EX != '0) &&
         ((rs_used_IF_ID && (rs_IF_ID == write_reg_ID_EX)) ||
          (rt_used_IF_ID && (rt_IF_ID == write_reg_ID_EX)));
    ld_stall  = (state == LD_STALL) || ((state == IDLE) && lu);
    md_hazard = (md_cnt != '0) && hilo_read_IF_ID;
    stall     = ld_stall || md_hazard;
    flush     = branch_taken_EX;
  end

  // Load FSM next state; a flush squashes the dependent instruction.
  always_comb begin
    state_nx  = state;
    ld_cnt_nx = ld_cnt;
    if (flush) begin
      state_nx  = IDLE;
      ld_cnt_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          if (lu && (LOAD_LAT > 1)) begin
            state_nx  = LD_STALL;
            ld_cnt_nx = LD_INIT;
          end
        end
        LD_STALL: begin
          if (ld_cnt <= LD_ONE) begin
            state_nx  = IDLE;
            ld_cnt_nx = '0;
          end else begin
            ld_cnt_nx = ld_cnt - LD_ONE;
          end
        end
        default: begin
          state_nx  = IDLE;
          ld_cnt_nx = '0;
        end
      endcase
    end
  end

  // HI/LO busy counter: a new MUL/DIV reloads, otherwise count down to 0.
  always_comb begin
    md_cnt_nx = md_cnt;
    if (md_start_ID_EX) begin
      md_cnt_nx = MD_INIT;
    end else if (md_cnt != '0) begin
      md_cnt_nx = md_cnt - MD_ONE;
    end
  end

  // Pipeline control outputs; flush wins over any stall.
  always_comb begin
    ControlUnitRst = 1'b0;
    pc_WE          = 1'b1;
    WE_if_id       = 1'b1;
    flush_if_id    = 1'b0;
    stall_active   = 1'b0;
    if (flush) begin
      flush_if_id    = 1'b1;
      ControlUnitRst = 1'b1;
    end else if (stall) begin
      ControlUnitRst = 1'b1;
      pc_WE          = 1'b0;
      WE_if_id       = 1'b0;
      stall_active   = 1'b1;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ld_cnt <= '0;
      md_cnt <= '0;
    end else begin
      state  <= state_nx;
      ld_cnt <= ld_cnt_nx;
      md_cnt <= md_cnt_nx;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Event counters; a cycle is attributed to exactly one cause (flush, then load, then md).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_stall_cnt <= '0;
      md_stall_cnt <= '0;
      flush_cnt    <= '0;
    end else begin
      if (flush) begin
        flush_cnt <= flush_cnt + 32'd1;
      end else if (ld_stall) begin
        ld_stall_cnt <= ld_stall_cnt + 32'd1;
      end else if (md_hazard) begin
        md_stall_cnt <= md_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Testbench for hazard_control_unit: two instances (LOAD_LAT=1 and LOAD_LAT=3)
// share stimulus; expected output vectors are queued per driven cycle and
// compared when the outputs settle.
module tb_hazard_control_unit;

  typedef struct packed {
    logic       mr;
    logic [4:0] wr;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rsu;
    logic       rtu;
    logic       mds;
    logic       hilo;
    logic       br;
  } stim_t;

  // {ControlUnitRst, pc_WE, WE_if_id, flush_if_id, stall_active}
  localparam logic [4:0] N = 5'b01100;
  localparam logic [4:0] S = 5'b10001;
  localparam logic [4:0] F = 5'b11110;

  logic       clk;
  logic       rst_n;
  logic       mr;
  logic [4:0] wr, rs, rt;
  logic       rsu, rtu, mds, hilo, br;

  logic cur1, pc1, we1, fl1, sa1;
  logic cur3, pc3, we3, fl3, sa3;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lsc1, msc1, fc1, lsc3, msc3, fc3;
`endif

  int tests;
  int fails;
  logic [9:0] sb[$];

  hazard_control_unit #(.REG_ADDR_W(5), .LOAD_LAT(1), .MULDIV_LAT(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .MemRead_ID_EX(mr), .write_reg_ID_EX(wr),
    .rs_IF_ID(rs), .rt_IF_ID(rt), .rs_used_IF_ID(rsu), .rt_used_IF_ID(rtu),
    .md_start_ID_EX(mds), .hilo_read_IF_ID(hilo), .branch_taken_EX(br),
    .ControlUnitRst(cur1), .pc_WE(pc1), .WE_if_id(we1), .flush_if_id(fl1),
    .stall_active(sa1)
`ifdef HAZARD_PERF_CNT_EN
    , .ld_stall_cnt(lsc1), .md_stall_cnt(msc1), .flush_cnt(fc1)
`endif
  );

  hazard_control_unit #(.REG_ADDR_W(5), .LOAD_LAT(3), .MULDIV_LAT(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .MemRead_ID_EX(mr), .write_reg_ID_EX(wr),
    .rs_IF_ID(rs), .rt_IF_ID(rt), .rs_used_IF_ID(rsu), .rt_used_IF_ID(rtu),
    .md_start_ID_EX(mds), .hilo_read_IF_ID(hilo), .branch_taken_EX(br),
    .ControlUnitRst(cur3), .pc_WE(pc3), .WE_if_id(we3), .flush_if_id(fl3),
    .stall_active(sa3)
`ifdef HAZARD_PERF_CNT_EN
    , .ld_stall_cnt(lsc3), .md_stall_cnt(msc3), .flush_cnt(fc3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(input logic m, input logic [4:0] w,
                               input logic [4:0] a, input logic [4:0] b,
                               input logic au, input logic bu, input logic md,
                               input logic hl, input logic bt);
    stim_t s;
    s.mr = m; s.wr = w; s.rs = a; s.rt = b; s.rsu = au; s.rtu = bu;
    s.mds = md; s.hilo = hl; s.br = bt;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [9:0] got();
    return {cur1, pc1, we1, fl1, sa1, cur3, pc3, we3, fl3, sa3};
  endfunction

  task automatic apply(input stim_t s);
    mr = s.mr; wr = s.wr; rs = s.rs; rt = s.rt; rsu = s.rsu; rtu = s.rtu;
    mds = s.mds; hilo = s.hilo; br = s.br;
  endtask

  // Drive one cycle's inputs away from the active edge and queue its expectation.
  task automatic drive(input stim_t s, input logic [9:0] e);
    @(negedge clk);
    apply(s);
    sb.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] e, g;
    rst_n = 1'b0;
    apply(idle());
    drive(idle(), {N, N});
    e = sb.pop_front(); g = got(); tests++;
    if (g !== e) begin fails++; $display("FAIL reset_held got=%b exp=%b", g, e); end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(idle(), {N, N});
      e = sb.pop_front(); g = got(); tests++;
      if (g !== e) begin fails++; $display("FAIL reset_after[%0d] got=%b exp=%b", i, g, e); end
    end
  endtask

  task automatic test_load_use();
    stim_t st[$]; logic [9:0] ex[$]; logic [9:0] e, g;
    // rs dependency
    st.push_back(mk(1, 8, 8, 0, 1, 0, 0, 0, 0)); ex.push_back({S, S});
    st.push_back(idle());                         ex.push_back({N, S});
    st.push_back(idle());                         ex.push_back({N, S});
    st.push_back(idle());                         ex.push_back({N, N});
    // rt dependency
    st.push_back(mk(1, 9, 3, 9, 1, 1, 0, 0, 0)); ex.push_back({S, S});
    st.push_back(idle());                         ex.push_back({N, S});
    st.push_back(idle());                         ex.push_back({N, S});
    st.push_back(idle());                         ex.push_back({N, N});
    foreach (st[i]) begin
      drive(st[i], ex[i]);
      e = sb.pop_front(); g = got(); tests++;
      if (g !== e) begin fails++; $display("FAIL load_use[%0d] got=%b exp=%b", i, g, e); end
    end
  endtask

  task automatic test_filtering();
    stim_t st[$]; logic [9:0] ex[$]; logic [9:0] e, g;
    st.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0)); ex.push_back({N, N});
    st.push_back(mk(1, 8, 0, 8, 1, 0, 0, 0, 0)); ex.push_back({N, N});
    st.push_back(mk(1, 8, 8, 0, 0, 0, 0, 0, 0)); ex.push_back({N, N});
    st.push_back(mk(0, 8, 8, 8, 1, 1, 0, 0, 0)); ex.push_back({N, N});
    st.push_back(idle());                         ex.push_back({N, N});
    foreach (st[i]) begin
      drive(st[i], ex[i]);
      e = sb.pop_front(); g = got(); tests++;
      if (g !== e) begin fails++; $display("FAIL filtering[%0d] got=%b exp=%b", i, g, e); end
    end
  endtask

  task automatic test_muldiv();
    stim_t st[$]; logic [9:0] ex[$]; logic [9:0] e, g;
    st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0)); ex.push_back({N, N});
    for (int i = 0; i < 4; i++) begin
      st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0)); ex.push_back({S, S});
    end
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0)); ex.push_back({N, N});
    foreach (st[i]) begin
      drive(st[i], ex[i]);
      e = sb.pop_front(); g = got(); tests++;
      if (g !== e) begin fails++; $display("FAIL muldiv[%0d] got=%b exp=%b", i, g, e); end
    end
  endtask

  task automatic test_md_restart();
    stim_t st[$]; logic [9:0] ex[$]; logic [9:0] e, g;
    st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0)); ex.push_back({N, N});
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back({N, N});
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0)); ex.push_back({S, S});
    st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0)); ex.push_back({S, S});
    for (int i = 0; i < 4; i++) begin
      st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0)); ex.push_back({S, S});
    end
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0)); ex.push_back({N, N});
    foreach (st[i]) begin
      drive(st[i], ex[i]);
      e = sb.pop_front(); g = got(); tests++;
      if (g !== e) begin fails++; $display("FAIL md_restart[%0d] got=%b exp=%b", i, g, e); end
    end
  endtask

  task automatic test_flush();
    stim_t st[$]; logic [9:0] ex[$]; logic [9:0] e, g;
    // flush during load stall cycle 2
    st.push_back(mk(1, 8, 8, 0, 1, 0, 0, 0, 0)); ex.push_back({S, S});
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back({F, F});
    st.push_back(idle());                         ex.push_back({N, N});
    st.push_back(idle());                         ex.push_back({N, N});
    // flush together with a fresh load-use
    st.push_back(mk(1, 8, 8, 0, 1, 0, 0, 0, 1)); ex.push_back({F, F});
    st.push_back(idle());                         ex.push_back({N, N});
    // flush over an md stall leaves the busy counter running
    st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0)); ex.push_back({N, N});
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1)); ex.push_back({F, F});
    for (int i = 0; i < 3; i++) begin
      st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0)); ex.push_back({S, S});
    end
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0)); ex.push_back({N, N});
    foreach (st[i]) begin
      drive(st[i], ex[i]);
      e = sb.pop_front(); g = got(); tests++;
      if (g !== e) begin fails++; $display("FAIL flush[%0d] got=%b exp=%b", i, g, e); end
    end
  endtask

  task automatic test_simultaneous();
    stim_t st[$]; logic [9:0] ex[$]; logic [9:0] e, g;
    st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0)); ex.push_back({N, N});
    st.push_back(mk(1, 8, 8, 0, 1, 0, 0, 1, 0)); ex.push_back({S, S});
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0)); ex.push_back({S, S});
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0)); ex.push_back({S, S});
    st.push_back(idle());                         ex.push_back({N, N});
    st.push_back(idle());                         ex.push_back({N, N});
    foreach (st[i]) begin
      drive(st[i], ex[i]);
      e = sb.pop_front(); g = got(); tests++;
      if (g !== e) begin fails++; $display("FAIL simultaneous[%0d] got=%b exp=%b", i, g, e); end
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] e, g;
    drive(mk(1, 8, 8, 0, 1, 0, 1, 0, 0), {S, S});
    e = sb.pop_front(); g = got(); tests++;
    if (g !== e) begin fails++; $display("FAIL async_pre0 got=%b exp=%b", g, e); end
    drive(idle(), {N, S});
    e = sb.pop_front(); g = got(); tests++;
    if (g !== e) begin fails++; $display("FAIL async_pre1 got=%b exp=%b", g, e); end
    #1 rst_n = 1'b0;
    #1 sb.push_back({N, N});
    e = sb.pop_front(); g = got(); tests++;
    if (g !== e) begin fails++; $display("FAIL async_assert got=%b exp=%b", g, e); end
    drive(idle(), {N, N});
    e = sb.pop_front(); g = got(); tests++;
    if (g !== e) begin fails++; $display("FAIL async_held got=%b exp=%b", g, e); end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), {N, N});
      e = sb.pop_front(); g = got(); tests++;
      if (g !== e) begin fails++; $display("FAIL async_md_cleared[%0d] got=%b exp=%b", i, g, e); end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_load_use();
    test_filtering();
    test_muldiv();
    test_md_restart();
    test_flush();
    test_simultaneous();
    test_async_reset();
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout reached required=finish");
    $fatal(1, "timeout");
  end

endmodule
